// File: rtl/voltmeter_pkg.sv
// Shared result-word layout for the voltmeter datapath, plus the packing helper
// used wherever a measurement is turned into a host-visible result word.
package voltmeter_pkg;

    localparam int RESULT_W      = 32;
    localparam int COUNT_W       = 16;
    localparam int SEQ_W         = 4;
    localparam int RANGE_W       = 3;

    localparam int SEQ_MSB       = 31;
    localparam int SEQ_LSB       = 28;
    localparam int RANGE_ERR_BIT = 27;
    localparam int SAT_HI_BIT    = 26;
    localparam int SAT_LO_BIT    = 25;
    localparam int REF_SIGN_BIT  = 24;
    localparam int RANGE_MSB     = 23;
    localparam int RANGE_LSB     = 21;
    localparam int OVF_BIT       = 20;
    localparam int COUNT_MSB     = 15;
    localparam int COUNT_LSB     = 0;

    // Bits [19:16] stay zero so the host can treat them as reserved.
    function automatic logic [RESULT_W-1:0] pack_result(
        input logic [SEQ_W-1:0]   seq,
        input logic               range_err,
        input logic               sat_hi,
        input logic               sat_lo,
        input logic               ref_sign,
        input logic [RANGE_W-1:0] range_sel,
        input logic               ovf,
        input logic [COUNT_W-1:0] count
    );
        logic [RESULT_W-1:0] w;
        w                       = '0;
        w[SEQ_MSB:SEQ_LSB]      = seq;
        w[RANGE_ERR_BIT]        = range_err;
        w[SAT_HI_BIT]           = sat_hi;
        w[SAT_LO_BIT]           = sat_lo;
        w[REF_SIGN_BIT]         = ref_sign;
        w[RANGE_MSB:RANGE_LSB]  = range_sel;
        w[OVF_BIT]              = ovf;
        w[COUNT_MSB:COUNT_LSB]  = count;
        return w;
    endfunction

endpackage

// File: rtl/meas_result_buffer_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and a registered occupancy count.
// A pop and push in the same cycle both succeed even when full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign pop_ok  = pop && !empty && !clear;
    assign push_ok = push && (!full || pop_ok) && !clear;
    assign rdata   = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + PTR_W'(1);
                2'b01:   level <= level - PTR_W'(1);
                default: level <= level;
            endcase
        end
    end

    // When full, a simultaneous push lands in the slot being popped; the old head is
    // read from storage before the write takes effect.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/meas_result_buffer.sv
// Packs measurement results into tagged 32-bit words, queues them for the SPI
// slave, and raises the host interrupt while enough results are waiting.
module meas_result_buffer
    import voltmeter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     done_i,
    input  logic [COUNT_W-1:0]       count_i,
    input  logic [RANGE_W-1:0]       range_sel_i,
    input  logic                     range_error_i,
    input  logic                     sat_hi_i,
    input  logic                     sat_lo_i,
    input  logic                     ref_sign_i,
    input  logic                     clear_i,
    input  logic                     tx_ack_i,
    output logic                     tx_valid_o,
    output logic [RESULT_W-1:0]      tx_word_o,
    output logic                     interrupt_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] IRQ_THRESH = LVL_W'(IRQ_LEVEL);

    logic [SEQ_W-1:0]    seq;
    logic [RESULT_W-1:0] new_word;
    logic                fifo_full;
    logic                fifo_empty;

    assign new_word = pack_result(seq, range_error_i, sat_hi_i, sat_lo_i,
                                  ref_sign_i, range_sel_i, overflow_o, count_i);

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear_i),
        .push  (done_i),
        .pop   (tx_ack_i),
        .wdata (new_word),
        .rdata (tx_word_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    // seq advances on every capture, even dropped ones, so the host can spot gaps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq        <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            seq        <= '0;
            overflow_o <= 1'b0;
        end else if (done_i) begin
            seq <= seq + SEQ_W'(1);
            if (fifo_full && !tx_ack_i) overflow_o <= 1'b1;
        end
    end

    assign tx_valid_o  = !fifo_empty;
    assign interrupt_o = (level_o >= IRQ_THRESH);

endmodule

// File: tb/tb_meas_result_buffer.sv
// Randomized and directed bench for meas_result_buffer, checked every cycle against
// a queue-based model of the result buffer.
module tb_meas_result_buffer;

    localparam int DEPTH     = 4;
    localparam int IRQ_LEVEL = 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        done_i = 1'b0;
    logic [15:0] count_i = '0;
    logic [2:0]  range_sel_i = '0;
    logic        range_error_i = 1'b0;
    logic        sat_hi_i = 1'b0;
    logic        sat_lo_i = 1'b0;
    logic        ref_sign_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        tx_ack_i = 1'b0;
    logic        tx_valid_o;
    logic [31:0] tx_word_o;
    logic        interrupt_o;
    logic        overflow_o;
    logic [2:0]  level_o;

    int checks = 0;
    int errors = 0;

    meas_result_buffer #(
        .DEPTH     (DEPTH),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .done_i        (done_i),
        .count_i       (count_i),
        .range_sel_i   (range_sel_i),
        .range_error_i (range_error_i),
        .sat_hi_i      (sat_hi_i),
        .sat_lo_i      (sat_lo_i),
        .ref_sign_i    (ref_sign_i),
        .clear_i       (clear_i),
        .tx_ack_i      (tx_ack_i),
        .tx_valid_o    (tx_valid_o),
        .tx_word_o     (tx_word_o),
        .interrupt_o   (interrupt_o),
        .overflow_o    (overflow_o),
        .level_o       (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: a queue of words plus the sequence tag and sticky overflow.
    logic [31:0] model_q[$];
    int          m_seq = 0;
    bit          m_ovf = 1'b0;
    bit          m_popped;
    logic [31:0] m_word;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            model_q.delete();
            m_seq = 0;
            m_ovf = 1'b0;
        end else begin
            m_word   = {m_seq[3:0], range_error_i, sat_hi_i, sat_lo_i, ref_sign_i,
                        range_sel_i, m_ovf, 4'b0000, count_i};
            m_popped = tx_ack_i && (model_q.size() > 0);
            if (m_popped) void'(model_q.pop_front());
            if (done_i) begin
                if (model_q.size() < DEPTH) model_q.push_back(m_word);
                else m_ovf = 1'b1;
                m_seq = (m_seq + 1) % 16;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk_i) begin
        checkOutput("valid",     {31'b0, tx_valid_o},  {31'b0, model_q.size() > 0});
        checkOutput("word",      tx_word_o,            (model_q.size() > 0) ? model_q[0] : 32'h0);
        checkOutput("level",     {29'b0, level_o},     32'(model_q.size()));
        checkOutput("interrupt", {31'b0, interrupt_o}, {31'b0, model_q.size() >= IRQ_LEVEL});
        checkOutput("overflow",  {31'b0, overflow_o},  {31'b0, m_ovf});
    end

    // Called at a falling edge; pulses last one clock, returns at the next falling edge.
    task automatic applyStimulus(input logic d, input logic [15:0] c, input logic [2:0] r,
                                 input logic [3:0] flags, input logic cl, input logic ack);
        done_i        = d;
        count_i       = c;
        range_sel_i   = r;
        range_error_i = flags[3];
        sat_hi_i      = flags[2];
        sat_lo_i      = flags[1];
        ref_sign_i    = flags[0];
        clear_i       = cl;
        tx_ack_i      = ack;
        @(posedge clk_i);
        #1;
        done_i   = 1'b0;
        clear_i  = 1'b0;
        tx_ack_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic capture(input logic [15:0] c);
        applyStimulus(1'b1, c, 3'd0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        applyStimulus(1'b0, 16'h0, 3'd0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic doClear();
        applyStimulus(1'b0, 16'h0, 3'd0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic asyncReset();
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rst_valid", {31'b0, tx_valid_o},  32'h0);
        checkOutput("rst_word",  tx_word_o,            32'h0);
        checkOutput("rst_level", {29'b0, level_o},     32'h0);
        checkOutput("rst_irq",   {31'b0, interrupt_o}, 32'h0);
        checkOutput("rst_ovf",   {31'b0, overflow_o},  32'h0);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset_level", {29'b0, level_o}, 32'h0);

        // First capture: literal word from the documented layout.
        applyStimulus(1'b1, 16'h1234, 3'd5, 4'b0001, 1'b0, 1'b0);
        checkOutput("first_word",  tx_word_o,            32'h01A0_1234);
        checkOutput("first_level", {29'b0, level_o},     32'h1);
        checkOutput("first_irq",   {31'b0, interrupt_o}, 32'h1);

        // Overflow: five captures into a four-deep buffer.
        doClear();
        for (int i = 0; i < 5; i++) capture(16'(i));
        checkOutput("ovf_level", {29'b0, level_o},    32'h4);
        checkOutput("ovf_flag",  {31'b0, overflow_o}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_head_seq", {28'b0, tx_word_o[31:28]}, 32'(i));
            ack();
        end
        capture(16'hBEEF);
        checkOutput("ovf_next_word", tx_word_o, 32'h5010_BEEF);

        // Full with simultaneous push and pop.
        doClear();
        for (int i = 0; i < 4; i++) capture(16'(i));
        applyStimulus(1'b1, 16'h00AA, 3'd0, 4'h0, 1'b0, 1'b1);
        checkOutput("fullpp_level", {29'b0, level_o},        32'h4);
        checkOutput("fullpp_ovf",   {31'b0, overflow_o},     32'h0);
        checkOutput("fullpp_head",  tx_word_o,               32'h1000_0001);
        repeat (3) ack();
        checkOutput("fullpp_tail",  tx_word_o,               32'h4000_00AA);

        // Empty: ack ignored, then simultaneous push and ack.
        doClear();
        ack();
        checkOutput("empty_ack_level", {29'b0, level_o}, 32'h0);
        checkOutput("empty_ack_word",  tx_word_o,        32'h0);
        applyStimulus(1'b1, 16'h0042, 3'd1, 4'h0, 1'b0, 1'b1);
        checkOutput("empty_pp_level", {29'b0, level_o}, 32'h1);
        checkOutput("empty_pp_word",  tx_word_o,        32'h0020_0042);

        // Clear coincident with a capture while holding three entries.
        doClear();
        for (int i = 0; i < 5; i++) capture(16'(i));
        ack();
        applyStimulus(1'b1, 16'h7777, 3'd2, 4'hF, 1'b1, 1'b0);
        checkOutput("clr_level", {29'b0, level_o},    32'h0);
        checkOutput("clr_valid", {31'b0, tx_valid_o}, 32'h0);
        checkOutput("clr_ovf",   {31'b0, overflow_o}, 32'h0);
        capture(16'h0001);
        checkOutput("clr_seq0", tx_word_o, 32'h0000_0001);

        // Sequence wrap across 17 capture/ack pairs.
        doClear();
        for (int i = 0; i < 17; i++) begin
            capture(16'(i));
            checkOutput("wrap_seq", {28'b0, tx_word_o[31:28]}, 32'(i % 16));
            ack();
        end

        // Randomized traffic with an asynchronous reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) asyncReset();
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom),
                          4'($urandom), ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 9) < 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
